// File: rtl/down_counter_seq.sv
// Loadable down-counter sequencer: loads an iteration budget, counts it down on
// enabled cycles, tracks elapsed steps, and pulses done for one cycle at terminal count.
module down_counter_seq #(
  parameter int COUNTER_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [COUNTER_WIDTH-1:0] load_value,
  input  logic                     enable,
  input  logic                     clear,
  output logic [COUNTER_WIDTH-1:0] count_o,
  output logic [COUNTER_WIDTH-1:0] index_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] ONE  = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] ZERO = '0;

  state_t                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic [COUNTER_WIDTH-1:0] index_q, index_d;
  logic [COUNTER_WIDTH-1:0] cap_q, cap_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= ZERO;
      index_q <= ZERO;
      cap_q   <= ZERO;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      cap_q   <= cap_d;
    end
  end

  // clear beats load beats enable; a load from RUN or DONE restarts like IDLE.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    cap_d   = cap_q;
    if (clear) begin
      state_d = IDLE;
      count_d = ZERO;
      index_d = ZERO;
    end else if (load) begin
      state_d = RUN;
      cap_d   = load_value;
      count_d = load_value;
      index_d = ZERO;
    end else begin
      case (state_q)
        RUN: begin
          if (enable) begin
            if (count_q != ZERO) begin
              count_d = count_q - ONE;
              // index + count always equals cap, so this guard only documents the bound.
              if (index_q != cap_q) begin
                index_d = index_q + ONE;
              end
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign count_o = count_q;
  assign index_o = index_q;
  assign busy_o  = (state_q == RUN);
  assign done_o  = (state_q == DONE);

endmodule

// File: tb/tb_down_counter_seq.sv
// Directed vector bench for down_counter_seq: a table of per-cycle stimulus with
// hand-computed outputs, plus asynchronous reset sequences with the clock running and stopped.
module tb_down_counter_seq;

  logic       clk;
  logic       clk_run;
  logic       rst;
  logic       load;
  logic [2:0] load_value;
  logic       enable;
  logic       clear;
  logic [2:0] count_o;
  logic [2:0] index_o;
  logic       busy_o;
  logic       done_o;

  int total;
  int bad;

  typedef struct {
    logic       ld;
    logic [2:0] lv;
    logic       en;
    logic       clr;
    logic [2:0] c;
    logic [2:0] i;
    logic       b;
    logic       d;
  } vec_t;

  vec_t vecs[36];

  down_counter_seq #(.COUNTER_WIDTH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .clear      (clear),
    .count_o    (count_o),
    .index_o    (index_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  function automatic vec_t mk(input logic ld, input logic [2:0] lv, input logic en,
                              input logic clr, input logic [2:0] c, input logic [2:0] i,
                              input logic b, input logic d);
    vec_t v;
    v.ld = ld; v.lv = lv; v.en = en; v.clr = clr;
    v.c = c; v.i = i; v.b = b; v.d = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [2:0] c, input logic [2:0] i,
                       input logic b, input logic d);
    total++;
    if (count_o !== c || index_o !== i || busy_o !== b || done_o !== d || (busy_o && done_o)) begin
      bad++;
      $display("FAIL %s: got count=%0d index=%0d busy=%0b done=%0b, want count=%0d index=%0d busy=%0b done=%0b",
               name, count_o, index_o, busy_o, done_o, c, i, b, d);
    end else begin
      $display("ok   %s: count=%0d index=%0d busy=%0b done=%0b", name, count_o, index_o, busy_o, done_o);
    end
  endtask

  task automatic step(input logic ld, input logic [2:0] lv, input logic en, input logic clr);
    @(negedge clk);
    load = ld; load_value = lv; enable = en; clear = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    clk_run = 1'b1;
    rst = 1'b0;
    load = 1'b0; load_value = 3'd0; enable = 1'b0; clear = 1'b0;

    // ld lv en clr -> count index busy done
    vecs[0]  = mk(0, 3'd0, 1, 0, 3'd0, 3'd0, 0, 0);  // enable ignored in IDLE
    vecs[1]  = mk(1, 3'd3, 0, 0, 3'd3, 3'd0, 1, 0);  // basic: load 3
    vecs[2]  = mk(0, 3'd0, 1, 0, 3'd2, 3'd1, 1, 0);
    vecs[3]  = mk(0, 3'd0, 1, 0, 3'd1, 3'd2, 1, 0);
    vecs[4]  = mk(0, 3'd0, 1, 0, 3'd0, 3'd3, 1, 0);
    vecs[5]  = mk(0, 3'd0, 1, 0, 3'd0, 3'd3, 0, 1);  // 4th enable -> done
    vecs[6]  = mk(0, 3'd0, 0, 0, 3'd0, 3'd3, 0, 0);  // IDLE, values held
    vecs[7]  = mk(1, 3'd5, 0, 0, 3'd5, 3'd0, 1, 0);  // pause: load 5
    vecs[8]  = mk(0, 3'd0, 1, 0, 3'd4, 3'd1, 1, 0);
    vecs[9]  = mk(0, 3'd0, 0, 0, 3'd4, 3'd1, 1, 0);
    vecs[10] = mk(0, 3'd0, 0, 0, 3'd4, 3'd1, 1, 0);
    vecs[11] = mk(0, 3'd0, 1, 0, 3'd3, 3'd2, 1, 0);
    vecs[12] = mk(1, 3'd6, 1, 0, 3'd6, 3'd0, 1, 0);  // load+enable: reload wins
    vecs[13] = mk(0, 3'd0, 1, 0, 3'd5, 3'd1, 1, 0);
    vecs[14] = mk(1, 3'd2, 1, 1, 3'd0, 3'd0, 0, 0);  // clear+load+enable: clear wins
    vecs[15] = mk(0, 3'd0, 1, 0, 3'd0, 3'd0, 0, 0);
    vecs[16] = mk(1, 3'd0, 0, 0, 3'd0, 3'd0, 1, 0);  // load 0
    vecs[17] = mk(0, 3'd0, 1, 0, 3'd0, 3'd0, 0, 1);  // one enable -> done
    vecs[18] = mk(0, 3'd0, 0, 0, 3'd0, 3'd0, 0, 0);
    vecs[19] = mk(1, 3'd7, 0, 0, 3'd7, 3'd0, 1, 0);  // load max
    vecs[20] = mk(0, 3'd0, 1, 0, 3'd6, 3'd1, 1, 0);
    vecs[21] = mk(0, 3'd0, 1, 0, 3'd5, 3'd2, 1, 0);
    vecs[22] = mk(0, 3'd0, 1, 0, 3'd4, 3'd3, 1, 0);
    vecs[23] = mk(0, 3'd0, 1, 0, 3'd3, 3'd4, 1, 0);
    vecs[24] = mk(0, 3'd0, 1, 0, 3'd2, 3'd5, 1, 0);
    vecs[25] = mk(0, 3'd0, 1, 0, 3'd1, 3'd6, 1, 0);
    vecs[26] = mk(0, 3'd0, 1, 0, 3'd0, 3'd7, 1, 0);
    vecs[27] = mk(0, 3'd0, 1, 0, 3'd0, 3'd7, 0, 1);  // no wrap, done
    vecs[28] = mk(0, 3'd0, 1, 0, 3'd0, 3'd7, 0, 0);
    vecs[29] = mk(1, 3'd3, 0, 0, 3'd3, 3'd0, 1, 0);  // restart sequence
    vecs[30] = mk(0, 3'd0, 1, 0, 3'd2, 3'd1, 1, 0);
    vecs[31] = mk(0, 3'd0, 1, 0, 3'd1, 3'd2, 1, 0);
    vecs[32] = mk(0, 3'd0, 1, 0, 3'd0, 3'd3, 1, 0);
    vecs[33] = mk(0, 3'd0, 1, 0, 3'd0, 3'd3, 0, 1);  // DONE cycle
    vecs[34] = mk(1, 3'd2, 0, 0, 3'd2, 3'd0, 1, 0);  // load in DONE -> RUN
    vecs[35] = mk(0, 3'd0, 0, 1, 3'd0, 3'd0, 0, 0);  // clear from RUN

    #12;
    check("reset_state", 3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 36; k++) begin
      step(vecs[k].ld, vecs[k].lv, vecs[k].en, vecs[k].clr);
      check($sformatf("vec%0d", k), vecs[k].c, vecs[k].i, vecs[k].b, vecs[k].d);
    end

    // Asynchronous reset mid-run, clock running.
    step(1, 3'd4, 0, 0);
    step(0, 3'd0, 1, 0);
    step(0, 3'd0, 1, 0);
    check("pre_reset_run", 3'd2, 3'd2, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_running", 3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(0, 3'd0, 1, 0);
    check("after_reset_idle", 3'd0, 3'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-run, clock stopped.
    step(1, 3'd4, 0, 0);
    step(0, 3'd0, 1, 0);
    step(0, 3'd0, 1, 0);
    check("pre_reset_stopped", 3'd2, 3'd2, 1'b1, 1'b0);
    @(negedge clk);
    enable = 1'b0;
    clk_run = 1'b0;
    #7;
    rst = 1'b0;
    #1;
    check("async_reset_stopped", 3'd0, 3'd0, 1'b0, 1'b0);
    #5;
    rst = 1'b1;
    clk_run = 1'b1;
    step(0, 3'd0, 1, 0);
    check("after_stopped_reset", 3'd0, 3'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
